cola_comandos: RTL
==================

# cola_comandos

Parametrised command queue between the debounced button decoder and the snake movement state machine. Buffers up to DEPTH direction commands in arrival order, rejects duplicates and overflow, and hands one command to the movement FSM per pop strobe. Successor to the fixed 6-entry, 3-bit button store: it adds configurable width and depth, true FIFO ordering, occupancy and status flags, a drop indication, and optional reverse-direction filtering.

## Interface
- CMD_W, 3: command width; code 0 = no command, 1..2^CMD_W-1 valid
- DEPTH, 6: queue entries, at least 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset; clears all state while low
- push  in  1  insert-request strobe, sampled each clk
- cmd_in  in  CMD_W  command to insert when push=1
- pop  in  1  request next command, sampled each clk
- cmd_out  out  CMD_W  registered, last command popped; 0 after a pop on empty
- cmd_valid  out  1  one-cycle pulse: cmd_out loaded with a non-zero command this cycle
- count  out  $clog2(DEPTH+1)  entries held
- full  out  1  count==DEPTH
- empty  out  1  count==0
- drop  out  1  one-cycle pulse: a push of a non-zero command was rejected

## Operation
- Storage: circular buffer, DEPTH x CMD_W, with wr_ptr/rd_ptr each in 0..DEPTH-1. Pointers wrap DEPTH-1 -> 0; DEPTH need not be a power of 2.
- Push with cmd_in==0: ignored; no store, no drop.
- Push with non-zero cmd_in is accepted when all hold:
  - not full, or pop asserted in the same cycle;
  - cmd_in matches no currently valid entry, including the head being popped this cycle;
  - opposite-direction check passes (see Configuration).
- Accepted push: writes buffer[wr_ptr], increments wr_ptr, updates last_acc <= cmd_in.
- Rejected push: no store; drop=1 next cycle.
- Pop, non-empty: cmd_out <= buffer[rd_ptr]; increment rd_ptr; cmd_valid=1.
- Pop, empty: cmd_out <= 0, cmd_valid=0. Not an error, no flag.
- No pop: cmd_out holds its value.
- Push and pop in the same cycle: pop takes the pre-edge head and push is evaluated on pre-edge state. count unchanged if both succeed. Empty + push + pop: pop yields 0 and the push is stored (no bypass).
- count/full/empty are registered and derived from next-state occupancy.

## Timing
- Reset (rst low, asynchronous):
  - cmd_out=0, cmd_valid=0, drop=0, count=0, full=0, empty=1;
  - pointers=0, last_acc=0; buffer contents don't-care.
- Release of rst is synchronised externally. The first edge after release is a normal cycle.
- Push latency: pushed entry is visible in count/empty one edge after the push is sampled. Earliest pop of it is the following cycle.
- Pop latency: cmd_out/cmd_valid valid one edge after pop is sampled.
- drop asserts the cycle after the rejected push, for one cycle.
- Reset asserted mid-operation discards all queued entries immediately. No partial pop is presented.
- Back-to-back push every cycle is supported until full; pop every cycle drains at 1/cycle.

## Configuration
- REJECT_OPPOSITE_EN defined: a push is also rejected (drop=1) when cmd_in is the reverse of last_acc. Pairs are 1<->2 (up/down) and 3<->4 (left/right); codes >=5 have no opposite. last_acc=0 (after reset) rejects nothing.
- REJECT_OPPOSITE_EN undefined: no opposite check; last_acc is not implemented.

## Test plan
- Reset, then push 1,3,2 on consecutive cycles, then pop x3 -> cmd_out 1,3,2 with cmd_valid each; count 3->0; empty=1; a 4th pop gives cmd_out=0, cmd_valid=0.
- DEPTH=6: push 1,2,3,4,5,6 (CMD_W=3) -> full=1; push 7 -> drop=1, count stays 6. Pop+push 7 in the same cycle -> count 6, 7 emerges last after 2..6.
- Push 3 twice -> second push gives drop=1, count=1. Pop (3 out) and push 3 in the same cycle -> drop=1. Next push 3 accepted.
- Push 0 with push=1 -> no count change, drop=0.
- With REJECT_OPPOSITE_EN: push 4 then 3 -> 3 dropped; push 1 accepted; push 2 dropped. Without the macro: all four stored.
- Queue holding 3 entries, assert rst low mid-cycle -> outputs at reset values before the next edge; after release, pop gives cmd_out=0.

Source files
------------

// File: rtl/cola_comandos_if.sv
// Handshake bundle between the button decoder (master) and the command queue (slave).
// Carries push/pop strobes, the command payload and the queue status flags.
interface cola_comandos_if #(
  parameter int CMD_W = 3,
  parameter int DEPTH = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic [CMD_W-1:0] cmd_in;
  logic             pop;
  logic [CMD_W-1:0] cmd_out;
  logic             cmd_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             drop;

  modport master (
    output push, cmd_in, pop,
    input  cmd_out, cmd_valid, count, full, empty, drop
  );

  modport slave (
    input  push, cmd_in, pop,
    output cmd_out, cmd_valid, count, full, empty, drop
  );
endinterface

// File: rtl/cola_comandos.sv
// Direction-command FIFO feeding the snake movement FSM; rejects duplicates and overflow.
// Define REJECT_OPPOSITE_EN to also reject a command that reverses the last accepted one.
module cola_comandos #(
  parameter int CMD_W = 3,
  parameter int DEPTH = 6
) (
  input logic             clk,
  input logic             rst,
  cola_comandos_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [CMD_W-1:0] cmd_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  cmd_t             buffer [DEPTH];
  logic [DEPTH-1:0] valid_q;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count_q;
  cmd_t             cmd_out_q;
  logic             cmd_valid_q;
  logic             drop_q;
  logic             full_q;
  logic             empty_q;

  logic             do_pop;
  logic             dup;
  logic             opp;
  logic             accept;
  logic             drop_next;
  cnt_t             count_next;
  logic [DEPTH-1:0] valid_next;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

`ifdef REJECT_OPPOSITE_EN
  cmd_t last_acc;

  // Up/down and left/right pairs; codes 0 and >=5 have no reverse.
  function automatic int opposite(input int c);
    case (c)
      1:       return 2;
      2:       return 1;
      3:       return 4;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    opp = (last_acc != '0) && (int'(bus.cmd_in) == opposite(int'(last_acc)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_acc <= '0;
    else if (accept) last_acc <= bus.cmd_in;
  end
`else
  always_comb begin
    opp = 1'b0;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    do_pop = bus.pop && !empty_q;

    // Duplicate check covers every held entry, including the head leaving this cycle.
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (buffer[i] == bus.cmd_in)) dup = 1'b1;
    end

    accept    = bus.push && (bus.cmd_in != '0) && (!full_q || bus.pop) && !dup && !opp;
    drop_next = bus.push && (bus.cmd_in != '0) && !accept;

    count_next = count_q + cnt_t'(accept) - cnt_t'(do_pop);

    // Clear before set: when full, push and pop share one slot.
    valid_next = valid_q;
    if (do_pop) valid_next[rd_ptr] = 1'b0;
    if (accept) valid_next[wr_ptr] = 1'b1;
  end

  // NOTE: storage has no reset; valid_q alone decides which slots hold live commands.
  always_ff @(posedge clk) begin
    if (accept) buffer[wr_ptr] <= bus.cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments so the pop reads the pre-edge head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      cmd_out_q   <= '0;
      cmd_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      valid_q     <= valid_next;
      count_q     <= count_next;
      full_q      <= (count_next == cnt_t'(DEPTH));
      empty_q     <= (count_next == '0);
      drop_q      <= drop_next;
      cmd_valid_q <= do_pop;
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (bus.pop) cmd_out_q <= do_pop ? buffer[rd_ptr] : '0;
    end
  end

  assign bus.cmd_out   = cmd_out_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.drop      = drop_q;
endmodule
